// File: rtl/data_memory_if.sv
// Bus bundle for the byte-enabled data memory: address, write controls and
// combinational read data. The master drives the request, the memory
// (slave) returns RD.
interface data_memory_if;
  logic [31:0] A;   // byte address
  logic        WE;  // write enable
  logic [3:0]  BE;  // byte-lane enables, BE[i] -> bits [8i+7:8i]
  logic [31:0] WD;  // write data, lane-aligned (not shifted by A[1:0])
  logic [31:0] RD;  // read data of the addressed word

  modport master (
    output A,
    output WE,
    output BE,
    output WD,
    input  RD
  );

  modport slave (
    input  A,
    input  WE,
    input  BE,
    input  WD,
    output RD
  );
endinterface

// File: rtl/data_memory.sv
// Word-organised data memory with per-byte write enables.
// - 2^MEM_ADDR_BITS bytes stored as 32-bit words, indexed by A[MEM_ADDR_BITS-1:2].
// - Writes on the rising clk edge; lanes are fixed (BE[i] -> bits 8i+7:8i).
// - Reads are combinational with no write-through bypass: RD shows the old
//   word until the edge, and the merged word immediately after it.
// - reset asynchronously clears every word and blocks writes while high.
module data_memory #(
  parameter int MEM_ADDR_BITS = 8
) (
  input  logic          clk,
  input  logic          reset,
  data_memory_if.slave  bus
);

  localparam int WORDS = 2 ** (MEM_ADDR_BITS - 2);

  logic [31:0]              mem_q [WORDS];
  logic [MEM_ADDR_BITS-3:0] word_idx;
  logic [31:0]              wr_word_d;

  // Byte offset and high address bits are deliberately ignored, so addresses
  // alias modulo the memory size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.A[1:0], bus.A[31:MEM_ADDR_BITS]};

  assign word_idx = bus.A[MEM_ADDR_BITS-1:2];

  // Merge enabled write lanes into the currently stored word.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments and starts from a
    // full default so every path assigns wr_word_d and no latch is inferred.
    wr_word_d = mem_q[word_idx];
    for (int i = 0; i < 4; i++) begin
      if (bus.BE[i]) begin
        wr_word_d[8*i +: 8] = bus.WD[8*i +: 8];
      end
    end
  end

  // Storage: async clear of every word, otherwise write the merged word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: clearing the whole array on reset forces flop-based storage; a
      // RAM macro cannot be cleared asynchronously, but this block requires it.
      for (int w = 0; w < WORDS; w++) begin
        mem_q[w] <= '0;
      end
    end else if (bus.WE) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every read of mem_q in this edge sees the pre-edge value.
      mem_q[word_idx] <= wr_word_d;
    end
  end

  // Combinational read of the addressed word; no bypass of WD.
  assign bus.RD = mem_q[word_idx];

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory. Inputs change just after the
// falling edge; outputs are sampled 1 time unit after changes or after the
// rising edge.
module tb_data_memory;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  data_memory_if bus ();

  data_memory #(.MEM_ADDR_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One registered write: set up after the falling edge, commit on the
  // rising edge, then drop WE.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd);
    @(negedge clk);
    bus.A  = addr;
    bus.BE = be;
    bus.WD = wd;
    bus.WE = 1'b1;
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [3];
    addrs = '{32'd0, 32'd4, 32'd252};
    bus.A = '0; bus.WE = 1'b0; bus.BE = '0; bus.WD = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      bus.A = addrs[i];
      #1;
      checks++;
      if (bus.RD !== 32'h0) begin
        failures++;
        $display("FAIL reset_clear A=%0d got=%h exp=%h", addrs[i], bus.RD, 32'h0);
      end
    end
    // Write attempt while reset is held must be blocked.
    @(negedge clk);
    reset = 1'b1;
    bus.A = 32'd0; bus.BE = 4'hF; bus.WD = 32'hFFFFFFFF; bus.WE = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.RD !== 32'h0) begin
      failures++;
      $display("FAIL reset_blocks_write got=%h exp=%h", bus.RD, 32'h0);
    end
    @(negedge clk);
    bus.WE = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.RD !== 32'h0) begin
      failures++;
      $display("FAIL reset_after_release got=%h exp=%h", bus.RD, 32'h0);
    end
  endtask

  task automatic test_single_lane();
    do_write(32'd3, 4'b1000, 32'hAB00000F);
    for (int a = 0; a < 4; a++) begin
      bus.A = a;
      #1;
      checks++;
      if (bus.RD !== 32'hAB000000) begin
        failures++;
        $display("FAIL single_lane A=%0d got=%h exp=%h", a, bus.RD, 32'hAB000000);
      end
    end
    bus.A = 32'd4;
    #1;
    checks++;
    if (bus.RD !== 32'h0) begin
      failures++;
      $display("FAIL single_lane_neighbour got=%h exp=%h", bus.RD, 32'h0);
    end
  endtask

  task automatic test_lane_merge();
    do_write(32'd6, 4'b0100, 32'h00FF0000);
    bus.A = 32'd4;
    #1;
    checks++;
    if (bus.RD !== 32'h00FF0000) begin
      failures++;
      $display("FAIL merge_lane2 got=%h exp=%h", bus.RD, 32'h00FF0000);
    end
    bus.A = 32'd1;
    #1;
    checks++;
    if (bus.RD !== 32'hAB000000) begin
      failures++;
      $display("FAIL merge_word0_kept got=%h exp=%h", bus.RD, 32'hAB000000);
    end
    do_write(32'd4, 4'b0011, 32'h12345678);
    #1;
    checks++;
    if (bus.RD !== 32'h00FF5678) begin
      failures++;
      $display("FAIL merge_low_lanes got=%h exp=%h", bus.RD, 32'h00FF5678);
    end
  endtask

  task automatic test_write_disable();
    @(negedge clk);
    bus.A = 32'd0; bus.WE = 1'b0; bus.BE = 4'hF; bus.WD = 32'hFFFFFFFF;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.RD !== 32'hAB000000) begin
        failures++;
        $display("FAIL we0_edge%0d got=%h exp=%h", e, bus.RD, 32'hAB000000);
      end
    end
    do_write(32'd0, 4'b0000, 32'hFFFFFFFF);
    #1;
    checks++;
    if (bus.RD !== 32'hAB000000) begin
      failures++;
      $display("FAIL we1_be0 got=%h exp=%h", bus.RD, 32'hAB000000);
    end
  endtask

  task automatic test_wrap_timing();
    @(negedge clk);
    bus.A = 32'd256; bus.BE = 4'hF; bus.WD = 32'hDEADBEEF; bus.WE = 1'b1;
    #1;
    checks++;
    if (bus.RD !== 32'hAB000000) begin
      failures++;
      $display("FAIL wrap_before_edge got=%h exp=%h", bus.RD, 32'hAB000000);
    end
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
    checks++;
    if (bus.RD !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wrap_after_edge got=%h exp=%h", bus.RD, 32'hDEADBEEF);
    end
    bus.A = 32'd0;
    #1;
    checks++;
    if (bus.RD !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wrap_alias_a0 got=%h exp=%h", bus.RD, 32'hDEADBEEF);
    end
    bus.A = 32'hFFFFFF04;
    #1;
    checks++;
    if (bus.RD !== 32'h00FF5678) begin
      failures++;
      $display("FAIL wrap_high_bits got=%h exp=%h", bus.RD, 32'h00FF5678);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] addrs [3];
    addrs = '{32'd0, 32'd4, 32'd252};
    bus.A = 32'd0;
    // Pending write set up, then discarded by a mid-cycle reset pulse.
    @(negedge clk);
    bus.BE = 4'hF; bus.WD = 32'h11111111; bus.WE = 1'b1;
    #1;
    checks++;
    if (bus.RD !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL async_pre got=%h exp=%h", bus.RD, 32'hDEADBEEF);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.RD !== 32'h0) begin
      failures++;
      $display("FAIL async_immediate got=%h exp=%h", bus.RD, 32'h0);
    end
    bus.WE = 1'b0;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      bus.A = addrs[i];
      #1;
      checks++;
      if (bus.RD !== 32'h0) begin
        failures++;
        $display("FAIL async_cleared A=%0d got=%h exp=%h", addrs[i], bus.RD, 32'h0);
      end
    end
  endtask

  task automatic test_first_write_after_reset();
    do_write(32'd8, 4'hF, 32'hCAFEF00D);
    #1;
    checks++;
    if (bus.RD !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL post_reset_write got=%h exp=%h", bus.RD, 32'hCAFEF00D);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.RD !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL retention got=%h exp=%h", bus.RD, 32'hCAFEF00D);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.A = '0; bus.WE = 1'b0; bus.BE = '0; bus.WD = '0;
    test_reset();
    test_single_lane();
    test_lane_merge();
    test_write_disable();
    test_wrap_timing();
    test_async_reset();
    test_first_write_after_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have parameter MEM_ADDR_BITS, default 8, giving the number of byte-address bits decoded (256 bytes, 64 words).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all writes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have port A, input, 32 bits, the byte address.
REQ-005 The block SHALL have port WE, input, 1 bit, the write enable.
REQ-006 The block SHALL have port BE, input, 4 bits, the byte-lane enables; BE[i] selects byte lane i.
REQ-007 The block SHALL have port WD, input, 32 bits, the write data.
REQ-008 The block SHALL have port RD, output, 32 bits, the read data.

Function
REQ-009 Storage SHALL be 2^MEM_ADDR_BITS/4 words of 32 bits, each word holding 4 byte lanes.
REQ-010 Word index SHALL be A[MEM_ADDR_BITS-1:2].
- A[1:0] ignored.
- A[31:MEM_ADDR_BITS] ignored, so addresses wrap modulo memory size.
REQ-011 Write SHALL occur at the rising clk edge when WE=1 and reset=0.
- For each i with BE[i]=1: bits [8i+7:8i] of the addressed word take WD[8i+7:8i].
- Lanes with BE[i]=0 are unchanged.
REQ-012 Lanes SHALL be fixed: BE[3]->bits 31:24, BE[2]->23:16, BE[1]->15:8, BE[0]->7:0.
- WD is not shifted by A[1:0].
REQ-013 WE=1 with BE=4'b0000 SHALL modify nothing.
REQ-014 WE=0 SHALL modify nothing, regardless of BE and WD.
REQ-015 Read SHALL be combinational: RD = word at A[MEM_ADDR_BITS-1:2], independent of WE and BE; zero-cycle latency.
REQ-016 Read-during-write to the same word SHALL be as follows.
- Before the edge: RD shows the old contents.
- After the edge: RD shows the merged new contents within the same cycle.
- No write-through bypass of WD.
REQ-017 Changing A SHALL update RD combinationally with no clock required.

Reset
REQ-018 Asserting reset SHALL asynchronously clear every word to 32'h00000000, without waiting for a clock edge.
REQ-019 While reset=1, RD SHALL be 32'h00000000 and all writes SHALL be blocked.
REQ-020 Reset asserted between edges during a write sequence SHALL discard any pending write.
REQ-021 After reset deasserts, the first rising edge with WE=1 SHALL perform a normal write.
REQ-022 Memory contents SHALL be retained indefinitely between writes while reset=0.

Verification
REQ-023 Reset scenario: pulse reset, then read A=0, 4, 252 -> RD=32'h00000000 each; issue WE=1 during reset -> no change.
REQ-024 Single-lane write scenario: write A=3, WE=1, BE=4'b1000, WD=32'hAB00000F; one edge; WE=0 -> RD=32'hAB000000 for A=0, 1, 2, 3.
REQ-025 Lane-merge scenario: after REQ-024, write A=6, WE=1, BE=4'b0100, WD=32'h00FF0000 -> word 1 reads 32'h00FF0000; then A=1 -> RD=32'hAB000000; then BE=4'b0011, WD=32'h12345678 at A=4 -> word 1 reads 32'h00FF5678.
REQ-026 Write-disable scenario: WE=0, BE=4'b1111, WD=32'hFFFFFFFF at A=0 over several edges -> RD unchanged at 32'hAB000000; WE=1 with BE=0 -> unchanged.
REQ-027 Wrap and timing scenario: write 32'hDEADBEEF (BE=1111) at A=256 -> RD at A=0 is 32'hDEADBEEF; RD equals the old value before the edge and the new value right after it.
REQ-028 Async reset scenario: assert reset mid-cycle with no clock edge -> RD goes to 0 immediately and all words read 0 afterward.
